// File: rtl/bridge_ahb_arbiter_pkg.sv
// bridge_arb_pkg: HTRANS encodings and arbiter state type shared by the bridge arbiter.
package bridge_arb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    typedef enum logic {ARB_PARK, ARB_OWN} arb_state_t;
endpackage

// File: rtl/bridge_ahb_arbiter_rr_pick.sv
// rr_pick: rotating-priority encoder; start_i has highest priority, wrapping upward.
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);
    int j;
    always_comb begin
        j       = 0;
        idx_o   = '0;
        valid_o = 1'b0;
        // walk lowest priority first so the highest-priority hit is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start_i) + k) % N;
            if (req_i[W'(j)]) begin
                idx_o   = W'(j);
                valid_o = 1'b1;
            end
        end
        gnt_o = valid_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/bridge_ahb_arbiter.sv
// bridge_ahb_arbiter: round-robin sharing of one AHB-to-APB bridge among NUM_MST masters.
// Define BRIDGE_ARB_TIMEOUT_EN to bound how long one owner may hold the bridge (MAX_HOLD).
module bridge_ahb_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int NUM_MST  = 3,
    parameter int MW       = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [NUM_MST-1:0]    hbusreq,
    input  logic [2*NUM_MST-1:0]  htrans_m,
    input  logic [32*NUM_MST-1:0] haddr_m,
    input  logic [NUM_MST-1:0]    hwrite_m,
    input  logic [32*NUM_MST-1:0] hwdata_m,
    input  logic                  hready,
    output logic [NUM_MST-1:0]    hgrant,
    output logic [MW-1:0]         hmaster,
    output logic [MW-1:0]         hmaster_data,
    output logic [1:0]            htrans,
    output logic [31:0]           haddr,
    output logic                  hwrite,
    output logic [31:0]           hwdata
);
    logic [NUM_MST-1:0] hgrant_q, hgrant_d, pick_gnt;
    logic [MW-1:0]      hmaster_q, hmaster_d, hmaster_data_q, start, pick_idx;
    arb_state_t         state_q, state_d;
    logic [1:0]         own_trans;
    logic               keep, force_rearb, pick_valid;

    assign own_trans = htrans_m[2*hmaster_q +: 2];
    assign start     = (hmaster_q == MW'(NUM_MST - 1)) ? '0 : hmaster_q + 1'b1;

    rr_pick #(.N(NUM_MST), .W(MW)) u_pick (
        .req_i   (hbusreq),
        .start_i (start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

`ifdef BRIDGE_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q;
    // preemption only at a burst start or idle slot so a burst is never split
    assign force_rearb = (hold_q >= HW'(MAX_HOLD - 1)) && (own_trans inside {HTRANS_NONSEQ, HTRANS_IDLE});
    always_ff @(posedge hclk) begin
        if (hreset)
            hold_q <= '0;
        else if (hready)
            hold_q <= (hmaster_d != hmaster_q) ? '0 :
                      (state_q == ARB_OWN && hold_q < HW'(MAX_HOLD - 1)) ? hold_q + 1'b1 : hold_q;
    end
`else
    assign force_rearb = 1'b0;
`endif

    always_comb begin
        keep      = hbusreq[hmaster_q] && (own_trans inside {HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ}) && !force_rearb;
        hmaster_d = keep ? hmaster_q : pick_valid ? pick_idx : '0;
        hgrant_d  = keep ? hgrant_q : pick_valid ? pick_gnt : NUM_MST'(1);
        state_d   = (|hbusreq) ? ARB_OWN : ARB_PARK;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_q       <= NUM_MST'(1);
            hmaster_q      <= '0;
            hmaster_data_q <= '0;
            state_q        <= ARB_PARK;
        end else if (hready) begin
            hgrant_q       <= hgrant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_q;
            state_q        <= state_d;
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign htrans       = hbusreq[hmaster_q] ? own_trans : HTRANS_IDLE;
    assign haddr        = haddr_m[32*hmaster_q +: 32];
    assign hwrite       = hwrite_m[hmaster_q];
    assign hwdata       = hwdata_m[32*hmaster_data_q +: 32];
endmodule

// File: tb/tb_bridge_ahb_arbiter.sv
// tb_bridge_ahb_arbiter: vector table, directed corner sequences and a random run against a reference model.
module tb_bridge_ahb_arbiter;
    localparam int N = 3;
    localparam int MAXH = 4;

    logic        clk = 0, rst = 1, rdy = 1;
    logic [2:0]  req = 0, wr = 0;
    logic [5:0]  trans = 0;
    logic [95:0] addr = 0, wdata = 0;
    logic [2:0]  hgrant;
    logic [1:0]  hmaster, hmd, htrans;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    int vecs = 0, errs = 0;
    int mo, md, mown, mhold;

    always #5 clk = ~clk;

    bridge_ahb_arbiter #(.NUM_MST(N), .MAX_HOLD(MAXH)) dut (
        .hclk(clk), .hreset(rst), .hbusreq(req), .htrans_m(trans), .haddr_m(addr),
        .hwrite_m(wr), .hwdata_m(wdata), .hready(rdy), .hgrant(hgrant), .hmaster(hmaster),
        .hmaster_data(hmd), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: owner keeps the bus during an active transfer, otherwise the
    // first requester in the circular order after the owner wins (owner last).
    task automatic model_step;
        logic [1:0] t;
        bit keep;
        int nxt;
        int order[$];
        if (rst) begin
            mo = 0; md = 0; mown = 0; mhold = 0;
        end else if (rdy) begin
            t = trans[2*mo +: 2];
            keep = req[mo] && t != 2'b00;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            if (mhold >= MAXH - 1 && (t == 2'b10 || t == 2'b00)) keep = 0;
`endif
            nxt = mo;
            if (!keep) begin
                for (int k = 1; k <= N; k++) order.push_back((mo + k) % N);
                while (order.size() > 0 && !req[order[0]]) void'(order.pop_front());
                nxt = (order.size() > 0) ? order[0] : 0;
            end
`ifdef BRIDGE_ARB_TIMEOUT_EN
            mhold = (nxt != mo) ? 0 : (mown != 0 && mhold < MAXH - 1) ? mhold + 1 : mhold;
`endif
            mown = (req != 0) ? 1 : 0;
            md = mo;
            mo = nxt;
        end
    endtask

    typedef struct {
        logic r; logic [2:0] rq; logic [5:0] tr; logic rd;
        logic [1:0] et; logic [2:0] eg; logic [1:0] em; logic [1:0] ed;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 3'b000, 6'b000000, 1'b1, 2'b00, 3'b001, 2'd0, 2'd0};
        tbl[1]  = '{1'b1, 3'b000, 6'b000000, 1'b1, 2'b00, 3'b001, 2'd0, 2'd0};
        tbl[2]  = '{1'b0, 3'b000, 6'b000000, 1'b1, 2'b00, 3'b001, 2'd0, 2'd0};
        tbl[3]  = '{1'b0, 3'b111, 6'b000000, 1'b1, 2'b00, 3'b010, 2'd1, 2'd0};
        tbl[4]  = '{1'b0, 3'b111, 6'b001000, 1'b1, 2'b10, 3'b010, 2'd1, 2'd1};
        tbl[5]  = '{1'b0, 3'b111, 6'b000000, 1'b1, 2'b00, 3'b100, 2'd2, 2'd1};
        tbl[6]  = '{1'b0, 3'b111, 6'b100000, 1'b1, 2'b10, 3'b100, 2'd2, 2'd2};
        tbl[7]  = '{1'b0, 3'b111, 6'b000000, 1'b1, 2'b00, 3'b001, 2'd0, 2'd2};
        tbl[8]  = '{1'b0, 3'b111, 6'b000010, 1'b1, 2'b10, 3'b001, 2'd0, 2'd0};
        tbl[9]  = '{1'b0, 3'b111, 6'b000000, 1'b1, 2'b00, 3'b010, 2'd1, 2'd0};
        tbl[10] = '{1'b0, 3'b111, 6'b001000, 1'b0, 2'b10, 3'b010, 2'd1, 2'd0};
        tbl[11] = '{1'b0, 3'b000, 6'b000000, 1'b1, 2'b00, 3'b001, 2'd0, 2'd1};
        tbl[12] = '{1'b0, 3'b100, 6'b000000, 1'b1, 2'b00, 3'b100, 2'd2, 2'd0};
        tbl[13] = '{1'b0, 3'b100, 6'b100000, 1'b1, 2'b10, 3'b100, 2'd2, 2'd2};
        tbl[14] = '{1'b0, 3'b100, 6'b000000, 1'b1, 2'b00, 3'b100, 2'd2, 2'd2};
        tbl[15] = '{1'b1, 3'b111, 6'b001000, 1'b1, 2'b00, 3'b001, 2'd0, 2'd0};
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].r; req = tbl[i].rq; trans = tbl[i].tr; rdy = tbl[i].rd;
            #1;
            if (!rst) chk($sformatf("tbl%0d htrans", i), htrans, tbl[i].et);
            tick;
            chk($sformatf("tbl%0d hgrant", i), hgrant, tbl[i].eg);
            chk($sformatf("tbl%0d hmaster", i), hmaster, tbl[i].em);
            chk($sformatf("tbl%0d hmaster_data", i), hmd, tbl[i].ed);
        end

        // burst hold with wait states mid-burst
        rst = 1; req = 0; trans = 0; rdy = 1; tick; rst = 0;
        req = 3'b110; tick;
        chk("burst grant m1", hmaster, 1);
        chk("burst hgrant m1", hgrant, 3'b010);
        trans = 6'b001000; #1; chk("burst nonseq htrans", htrans, 2'b10);
        tick; chk("burst nonseq hold", hmaster, 1);
        trans = 6'b001100; tick;
        chk("burst seq1 hold", hmaster, 1);
        chk("burst seq1 data owner", hmd, 1);
        req = 3'b111; wdata[63:32] = 32'hA5A5_0001; rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("wait hwdata", hwdata, 32'hA5A5_0001);
            tick;
            chk("wait hgrant", hgrant, 3'b010);
            chk("wait data owner", hmd, 1);
        end
        rdy = 1; tick; chk("burst seq2 hold", hmaster, 1);
        tick; chk("burst seq3 hold", hmaster, 1);
        trans = 0; tick;
        chk("burst end next m2", hmaster, 2);
        chk("burst end hgrant", hgrant, 3'b100);

        // back-to-back writes: data-phase mux lags the address owner
        rst = 1; req = 0; trans = 0; tick; rst = 0;
        addr = {32'h3000, 32'h2000, 32'h1000}; wdata = {32'h20, 32'h0, 32'h10}; wr = 3'b101;
        req = 3'b001; trans = 6'b000010; tick;
        chk("b2b m0 owner", hmaster, 0);
        req = 3'b100; trans = 6'b000000; tick;
        chk("b2b m2 owner", hmaster, 2);
        trans = 6'b100000; #1;
        chk("b2b hwdata m0", hwdata, 32'h10);
        chk("b2b haddr m2", haddr, 32'h3000);
        chk("b2b hwrite", hwrite, 1);
        tick;
        chk("b2b data owner m2", hmd, 2);
        chk("b2b hwdata m2", hwdata, 32'h20);

        // continuous NONSEQ from m0 with m1 waiting
        rst = 1; req = 0; trans = 0; tick; rst = 0;
        req = 3'b011; trans = 6'b000010;
`ifdef BRIDGE_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick; chk("timeout m0 holds", hmaster, 0);
        end
        tick; chk("timeout switch m1", hmaster, 1);
`else
        for (int i = 0; i < 20; i++) begin
            tick; chk("no timeout m0 holds", hmaster, 0);
        end
`endif

        // random traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 199) == 0);
            req = 3'($urandom); trans = 6'($urandom); wr = 3'($urandom);
            rdy = $urandom_range(0, 3) != 0;
            addr = {$urandom, $urandom, $urandom};
            wdata = {$urandom, $urandom, $urandom};
            #1;
            if (c > 0) begin
                chk("rnd htrans", htrans, req[mo] ? trans[2*mo +: 2] : 2'b00);
                chk("rnd haddr", haddr, addr[32*mo +: 32]);
                chk("rnd hwrite", hwrite, wr[mo]);
                chk("rnd hwdata", hwdata, wdata[32*md +: 32]);
            end
            model_step();
            tick;
            chk("rnd hgrant", hgrant, 3'b001 << mo);
            chk("rnd hmaster", hmaster, mo);
            chk("rnd hmaster_data", hmd, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
